risc_v_mike_bus_fabric: RTL and testbench

Parametrised memory-bus fabric between the multicycle core's single address/data port and NUM_SLV memory-mapped targets (text, data, stack, MMIO, …). It replaces the fixed 4-region combinational address select with a registered, handshaked transaction engine. The engine supports per-slave wait states, a decode-error response, a timeout watchdog and a saturating error counter.

---
 rtl/risc_v_mike_pkg.sv | 28 ++
 rtl/risc_v_mike_bus_decoder.sv | 36 +++
 rtl/risc_v_mike_bus_fabric.sv | 165 ++++++++++++++++
 tb/tb_risc_v_mike_bus_fabric.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike core and its memory bus.
package risc_v_mike_pkg;

  // Bus transaction engine states.
  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACCESS = 2'd1,
    BUS_RESP   = 2'd2
  } t_bus_state;

  localparam int BUS_ERR_CNT_W = 8;

  // Default memory map: text, data, stack and MMIO regions (slaves 0..3).
  localparam logic [31:0] BUS_TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] BUS_TEXT_MASK  = 32'hFFF0_0000;
  localparam logic [31:0] BUS_DATA_BASE  = 32'h1001_0000;
  localparam logic [31:0] BUS_DATA_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] BUS_STACK_BASE = 32'h7FFF_0000;
  localparam logic [31:0] BUS_STACK_MASK = 32'hFFFF_0000;
  localparam logic [31:0] BUS_MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] BUS_MMIO_MASK  = 32'hFFFF_0000;

  localparam logic [127:0] BUS_DEFAULT_BASE =
    {BUS_MMIO_BASE, BUS_STACK_BASE, BUS_DATA_BASE, BUS_TEXT_BASE};
  localparam logic [127:0] BUS_DEFAULT_MASK =
    {BUS_MMIO_MASK, BUS_STACK_MASK, BUS_DATA_MASK, BUS_TEXT_MASK};

endpackage

// File: rtl/risc_v_mike_bus_decoder.sv
// Combinational address decoder: per-region match, lowest index wins.
module risc_v_mike_bus_decoder #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0,
  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_SLV-1:0] onehot
);

  logic [NUM_SLV-1:0] match;

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_match
    assign match[gi] =
      (addr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
  end

  // Scan from the top so the lowest matching index is the last to win.
  always_comb begin
    hit    = |match;
    idx    = '0;
    onehot = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/risc_v_mike_bus_fabric.sv
// Registered, handshaked bus fabric between the core port and NUM_SLV slaves.
module risc_v_mike_bus_fabric
  import risc_v_mike_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mst_req,
  output logic                      mst_gnt,
  input  logic                      mst_write,
  input  logic [ADDR_W-1:0]         mst_addr,
  input  logic [DATA_W-1:0]         mst_wdata,
  output logic                      mst_rsp_valid,
  output logic [DATA_W-1:0]         mst_rdata,
  output logic                      mst_err,
  output logic [NUM_SLV-1:0]        slv_sel,
  output logic                      slv_write,
  output logic [ADDR_W-1:0]         slv_addr,
  output logic [DATA_W-1:0]         slv_wdata,
  input  logic [NUM_SLV-1:0]        slv_ready,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
  output logic [7:0]                err_cnt
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [BUS_ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  t_bus_state state_reg, state_next;
  logic [ADDR_W-1:0]        addr_reg, addr_next;
  logic [DATA_W-1:0]        wdata_reg, wdata_next;
  logic                     write_reg, write_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [NUM_SLV-1:0]       sel_reg, sel_next;
  logic                     err_reg, err_next;
  logic [DATA_W-1:0]        rdata_reg, rdata_next;
  logic [7:0]               wait_reg, wait_next;
  logic [BUS_ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [NUM_SLV-1:0] dec_onehot;

  logic               sel_ready;
  logic [DATA_W-1:0]  sel_rdata;
  logic [ADDR_W-1:0]  sel_mask;
  logic               in_access;

  risc_v_mike_bus_decoder #(
    .NUM_SLV  (NUM_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decoder (
    .addr   (mst_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  assign sel_ready = slv_ready[idx_reg];
  assign sel_rdata = slv_rdata[int'(idx_reg)*DATA_W +: DATA_W];
  assign sel_mask  = SLV_MASK[int'(idx_reg)*ADDR_W +: ADDR_W];
  assign in_access = (state_reg == BUS_ACCESS);

  // Slave-side signals come only from registered transaction state.
  assign slv_sel       = in_access ? sel_reg : '0;
  assign slv_write     = in_access & write_reg;
  assign slv_addr      = in_access ? (addr_reg & ~sel_mask) : '0;
  assign slv_wdata     = in_access ? wdata_reg : '0;
  assign mst_rsp_valid = (state_reg == BUS_RESP);
  assign mst_err       = (state_reg == BUS_RESP) & err_reg;
  assign mst_rdata     = rdata_reg;
  assign err_cnt       = err_cnt_reg;

  // State and transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= BUS_IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      write_reg   <= 1'b0;
      idx_reg     <= '0;
      sel_reg     <= '0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
      wait_reg    <= '0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      write_reg   <= write_next;
      idx_reg     <= idx_next;
      sel_reg     <= sel_next;
      err_reg     <= err_next;
      rdata_reg   <= rdata_next;
      wait_reg    <= wait_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  // Next-state logic: grant in IDLE, wait for ready or timeout, one-cycle response.
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    write_next   = write_reg;
    idx_next     = idx_reg;
    sel_next     = sel_reg;
    err_next     = err_reg;
    rdata_next   = rdata_reg;
    wait_next    = wait_reg;
    err_cnt_next = err_cnt_reg;
    mst_gnt      = 1'b0;
    case (state_reg)
      BUS_IDLE: begin
        mst_gnt = mst_req & rst;
        if (mst_req) begin
          addr_next  = mst_addr;
          wdata_next = mst_wdata;
          write_next = mst_write;
          idx_next   = dec_idx;
          sel_next   = dec_onehot;
          wait_next  = '0;
          if (dec_hit) begin
            state_next = BUS_ACCESS;
          end else begin
            err_next   = 1'b1;
            rdata_next = '0;
            state_next = BUS_RESP;
          end
        end
      end
      BUS_ACCESS: begin
        wait_next = wait_reg + 8'd1;
        if (sel_ready) begin
          rdata_next = write_reg ? '0 : sel_rdata;
          err_next   = 1'b0;
          wait_next  = '0;
          state_next = BUS_RESP;
        end else if (wait_reg == TIMEOUT_C) begin
          rdata_next = '0;
          err_next   = 1'b1;
          wait_next  = '0;
          state_next = BUS_RESP;
        end
      end
      BUS_RESP: begin
        state_next = BUS_IDLE;
        if (err_reg && (err_cnt_reg != ERR_CNT_MAX)) begin
          err_cnt_next = err_cnt_reg + 1'b1;
        end
      end
      default: state_next = BUS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_v_mike_bus_fabric.sv
// Scoreboard bench for risc_v_mike_bus_fabric: driver pushes expected
// responses, an independent monitor pops and compares them.
module tb_risc_v_mike_bus_fabric;

  localparam int NUM_SLV = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam logic [NUM_SLV*ADDR_W-1:0] BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1001_0000, 32'h2000_0000};
  localparam logic [NUM_SLV*ADDR_W-1:0] MASK =
    {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};

  logic                      clk;
  logic                      rst;
  logic                      mst_req;
  logic                      mst_gnt;
  logic                      mst_write;
  logic [ADDR_W-1:0]         mst_addr;
  logic [DATA_W-1:0]         mst_wdata;
  logic                      mst_rsp_valid;
  logic [DATA_W-1:0]         mst_rdata;
  logic                      mst_err;
  logic [NUM_SLV-1:0]        slv_sel;
  logic                      slv_write;
  logic [ADDR_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [NUM_SLV-1:0]        slv_ready;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;
  logic [7:0]                err_cnt;

  risc_v_mike_bus_fabric #(
    .NUM_SLV  (NUM_SLV),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SLV_BASE (BASE),
    .SLV_MASK (MASK),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mst_req       (mst_req),
    .mst_gnt       (mst_gnt),
    .mst_write     (mst_write),
    .mst_addr      (mst_addr),
    .mst_wdata     (mst_wdata),
    .mst_rsp_valid (mst_rsp_valid),
    .mst_rdata     (mst_rdata),
    .mst_err       (mst_err),
    .slv_sel       (slv_sel),
    .slv_write     (slv_write),
    .slv_addr      (slv_addr),
    .slv_wdata     (slv_wdata),
    .slv_ready     (slv_ready),
    .slv_rdata     (slv_rdata),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: ready once the access has lasted wait_cfg cycles.
  // Unselected slaves may also show ready; the fabric must ignore them.
  int wait_cfg [NUM_SLV];
  int acc_cnt = 0;
  always @(posedge clk) acc_cnt <= (slv_sel != '0) ? acc_cnt + 1 : 0;
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
    assign slv_ready[gi] = (acc_cnt >= wait_cfg[gi]);
  end
  assign slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_AAAA};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int n_rsp = 0;
  int exp_errcnt = 0;
  int last_gnt = 0;
  logic [3:0]  exp_sel = '0;
  logic [31:0] exp_saddr = '0;
  logic        exp_swrite = 1'b0;
  logic [31:0] exp_swdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks slave-side signals every access cycle and pops one
  // expectation per response.
  always @(negedge clk) begin
    if (rst) begin
      if (slv_sel != '0) begin
        chk("slv_sel", 32'(slv_sel), 32'(exp_sel));
        chk("slv_addr", slv_addr, exp_saddr);
        chk("slv_write", 32'(slv_write), 32'(exp_swrite));
        chk("slv_wdata", slv_wdata, exp_swdata);
      end
      if (mst_rsp_valid) begin
        n_rsp++;
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(mst_rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_rdata", mst_rdata, e.rdata);
          chk("rsp_err", 32'(mst_err), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("gnt_in_resp", 32'(mst_gnt), 32'd0);
          $display("rsp %0d: cycle %0d rdata %h err %0d", n_rsp, cyc, mst_rdata, mst_err);
        end
      end
    end
  end

  // Driver: present a request, wait (bounded) for grant, record expectations.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sel, input logic [31:0] saddr,
                        input logic [31:0] rd, input logic err, input int lat,
                        input bit hold, input bit push, input bit gap_chk);
    bit granted;
    exp_t e;
    granted = 1'b0;
    @(negedge clk);
    mst_req   = 1'b1;
    mst_write = w;
    mst_addr  = a;
    mst_wdata = wd;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (mst_gnt === 1'b1) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!granted) begin
      chk("grant_timeout", 32'(mst_gnt), 32'd1);
      mst_req = 1'b0;
      return;
    end
    if (gap_chk) chk("grant_gap", 32'(cyc - last_gnt), 32'd3);
    last_gnt   = cyc;
    exp_sel    = sel;
    exp_saddr  = saddr;
    exp_swrite = w;
    exp_swdata = wd;
    if (push) begin
      e.rdata = rd;
      e.err   = err;
      e.cyc   = cyc + lat;
      q.push_back(e);
      if (err && exp_errcnt < 255) exp_errcnt++;
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      mst_req = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_SLV; i++) wait_cfg[i] = 0;
    wait_cfg[3] = 3;
    rst       = 1'b0;
    mst_req   = 1'b1;
    mst_write = 1'b0;
    mst_addr  = 32'h1001_0000;
    mst_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(mst_gnt), 32'd0);
    chk("reset_sel", 32'(slv_sel), 32'd0);
    chk("reset_rsp_valid", 32'(mst_rsp_valid), 32'd0);
    chk("reset_rdata", mst_rdata, 32'd0);
    chk("reset_err", 32'(mst_err), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_slv_addr", slv_addr, 32'd0);
    mst_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait read from slave 1.
    do_txn(1'b0, 32'h1001_0004, 32'h0, 4'b0010, 32'h4, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    drain();
    // Three-wait write to slave 3.
    do_txn(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'b1000, 32'h10, 32'h0, 1'b0, 5, 1'b0, 1'b1, 1'b0);
    drain();
    // Decode error.
    do_txn(1'b0, 32'h4000_0000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1, 1'b0);
    drain();
    chk("err_cnt_decode", 32'(err_cnt), 32'(exp_errcnt));
    // Timeout: slave 3 never ready.
    wait_cfg[3] = 255;
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'b1000, 32'h20, 32'h0, 1'b1, 6, 1'b0, 1'b1, 1'b0);
    drain();
    chk("err_cnt_timeout", 32'(err_cnt), 32'(exp_errcnt));
    wait_cfg[3] = 3;
    // Overlapping regions, request held back-to-back: slave 0 must win.
    do_txn(1'b0, 32'h2000_1008, 32'h0, 4'b0001, 32'h0000_1008, 32'h0000_AAAA, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    do_txn(1'b0, 32'h2000_1008, 32'h0, 4'b0001, 32'h0000_1008, 32'h0000_AAAA, 1'b0, 2, 1'b1, 1'b1, 1'b1);
    do_txn(1'b0, 32'h2000_1008, 32'h0, 4'b0001, 32'h0000_1008, 32'h0000_AAAA, 1'b0, 2, 1'b0, 1'b1, 1'b1);
    drain();
    // 300 consecutive decode errors saturate the counter.
    for (int i = 0; i < 300; i++) begin
      do_txn(1'b0, 32'h5000_0000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, (i != 299), 1'b1, 1'b0);
    end
    drain();
    chk("err_cnt_saturate", 32'(err_cnt), 32'hFF);
    // Reset during ACCESS aborts the transaction without a response.
    do_txn(1'b0, 32'h3000_0000, 32'h0, 4'b1000, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_sel", 32'(slv_sel), 32'd0);
    chk("abort_rsp_valid", 32'(mst_rsp_valid), 32'd0);
    chk("abort_slv_write", 32'(slv_write), 32'd0);
    chk("abort_err_cnt", 32'(err_cnt), 32'd0);
    exp_errcnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Fresh request after reset release completes normally.
    do_txn(1'b0, 32'h1001_0008, 32'h0, 4'b0010, 32'h8, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    drain();
    chk("err_cnt_final", 32'(err_cnt), 32'(exp_errcnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
